vga_pattern_gen: RTL and testbench

- Pixel source that sits directly downstream of the VGA timing generator.
- Consumes the raw horizontal/vertical counters, DRAW window and sync pulses, and produces 24-bit RGB plus sync/enable delayed by a fixed pipeline latency.
- Provides four selectable test patterns, one of them animated once per frame, for board bring-up and monitor checks.

---
 rtl/vga_pattern_gen.sv | 253 +++++++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
//   Test-pattern pixel source placed directly after the VGA timing generator.
//   It turns the raw counters into active-area coordinates and draws one of four
//   patterns. RGB, HS, VS and DE leave the block exactly 2 cycles after the
//   corresponding inputs arrive.
//
//   Optional feature: define PATTERN_BORDER_EN to draw a one-pixel white border
//   on the edge pixels of the active area. The border overrides every pattern.
//
// Ports
//   CLK     in   1   pixel clock
//   CLR     in   1   synchronous active-high reset
//   H_CNT   in  10   horizontal counter from the timing generator
//   V_CNT   in  10   vertical counter from the timing generator
//   DRAW_I  in   1   active-video window
//   HS_I    in   1   horizontal sync, active-high
//   VS_I    in   1   vertical sync, active-high; its rising edge marks frame start
//   MODE    in   2   pattern select: 0 bars, 1 checker, 2 gradient, 3 box
//   R/G/B   out  8   pixel colour, zero outside the active window
//   HS/VS   out  1   HS_I/VS_I delayed by 2 cycles
//   DE      out  1   DRAW_I delayed by 2 cycles
// -----------------------------------------------------------------------------
module vga_pattern_gen #(
  parameter int unsigned H_START  = 144,
  parameter int unsigned V_START  = 35,
  parameter int unsigned H_ACT    = 640,
  parameter int unsigned V_ACT    = 480,
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned SPEED    = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [9:0] H_CNT,
  input  logic [9:0] V_CNT,
  input  logic       DRAW_I,
  input  logic       HS_I,
  input  logic       VS_I,
  input  logic [1:0] MODE,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       HS,
  output logic       VS,
  output logic       DE
);

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  typedef struct packed {
    dir_t       dir;
    logic [9:0] pos;
  } axis_t;

  localparam logic [9:0]  LP_H_START = 10'(H_START);
  localparam logic [9:0]  LP_V_START = 10'(V_START);
  localparam logic [10:0] LP_H_ACT   = 11'(H_ACT);
  localparam logic [9:0]  LP_MAX_X   = 10'(H_ACT - BOX_SIZE);
  localparam logic [9:0]  LP_MAX_Y   = 10'(V_ACT - BOX_SIZE);
  localparam logic [9:0]  LP_SPEED   = 10'(SPEED);
  localparam logic [10:0] LP_BOX     = 11'(BOX_SIZE);
  localparam int unsigned LP_BAR_W   = H_ACT / 8;

  // Stage 1
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_draw1;
  logic       r_hs1;
  logic       r_vs1;

  // Per-frame state
  mode_t      r_mode;
  logic [9:0] r_bx;
  logic [9:0] r_by;
  dir_t       r_dx;
  dir_t       r_dy;

  logic       w_frame_start;
  axis_t      w_nx;
  axis_t      w_ny;
  logic [2:0] w_bar;
  logic       w_in_box;
  logic [7:0] w_r;
  logic [7:0] w_g;
  logic [7:0] w_b;

  // The stage-1 VS register doubles as the frame-start edge detector.
  assign w_frame_start = VS_I & ~r_vs1;

  // One axis of the bouncing box: step by SPEED, reflecting at 0 and max.
  // The overflow test is done in 11 bits so pos+SPEED can never wrap.
  function automatic axis_t step_axis(input dir_t d, input logic [9:0] p,
                                      input logic [9:0] max);
    axis_t s;
    s.dir = d;
    s.pos = p;
    if (d == DIR_POS) begin
      if (({1'b0, p} + {1'b0, LP_SPEED}) > {1'b0, max}) begin
        s.dir = DIR_NEG;
        s.pos = p - LP_SPEED;
      end else begin
        s.pos = p + LP_SPEED;
      end
    end else begin
      if (p < LP_SPEED) begin
        s.dir = DIR_POS;
        s.pos = p + LP_SPEED;
      end else begin
        s.pos = p - LP_SPEED;
      end
    end
    return s;
  endfunction

  always_comb begin
    w_nx = step_axis(r_dx, r_bx, LP_MAX_X);
    w_ny = step_axis(r_dy, r_by, LP_MAX_Y);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_x     <= '0;
      r_y     <= '0;
      r_draw1 <= 1'b0;
      r_hs1   <= 1'b0;
      r_vs1   <= 1'b0;
    end else begin
      r_x     <= H_CNT - LP_H_START;
      r_y     <= V_CNT - LP_V_START;
      r_draw1 <= DRAW_I;
      r_hs1   <= HS_I;
      r_vs1   <= VS_I;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_mode <= MODE_BARS;
      r_bx   <= '0;
      r_by   <= '0;
      r_dx   <= DIR_POS;
      r_dy   <= DIR_POS;
    end else if (w_frame_start) begin
      r_mode <= mode_t'(MODE);
      r_bx   <= w_nx.pos;
      r_dx   <= w_nx.dir;
      r_by   <= w_ny.pos;
      r_dy   <= w_ny.dir;
    end
  end

  // Bar index: the last threshold that x has reached wins.
  always_comb begin
    w_bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if ({1'b0, r_x} >= 11'(LP_BAR_W * k)) begin
        w_bar = 3'(k);
      end
    end
  end

  assign w_in_box = (r_x >= r_bx) && ({1'b0, r_x} < ({1'b0, r_bx} + LP_BOX)) &&
                    (r_y >= r_by) && ({1'b0, r_y} < ({1'b0, r_by} + LP_BOX));

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    unique case (r_mode)
      MODE_BARS: begin
        unique case (w_bar)
          3'd0: begin w_r = '1;    w_g = '1;    w_b = '1;    end
          3'd1: begin w_r = '1;    w_g = '1;    w_b = '0;    end
          3'd2: begin w_r = '0;    w_g = '1;    w_b = '1;    end
          3'd3: begin w_r = '0;    w_g = '1;    w_b = '0;    end
          3'd4: begin w_r = '1;    w_g = '0;    w_b = '1;    end
          3'd5: begin w_r = '1;    w_g = '0;    w_b = '0;    end
          3'd6: begin w_r = '0;    w_g = '0;    w_b = '1;    end
          3'd7: begin w_r = '0;    w_g = '0;    w_b = '0;    end
        endcase
        if ({1'b0, r_x} >= LP_H_ACT) begin
          w_r = '0;
          w_g = '0;
          w_b = '0;
        end
      end
      MODE_CHECK: begin
        if (r_x[5] ^ r_y[5]) begin
          w_r = '1;
          w_g = '1;
          w_b = '1;
        end
      end
      MODE_GRAD: begin
        w_r = r_x[7:0];
        w_g = r_y[7:0];
        w_b = 8'(({1'b0, r_x} + {1'b0, r_y}) >> 1);
      end
      MODE_BOX: begin
        if (w_in_box) begin
          w_r = 8'd255;
          w_g = 8'd127;
          w_b = 8'd64;
        end else begin
          w_b = 8'd64;
        end
      end
    endcase
`ifdef PATTERN_BORDER_EN
    if ((r_x == '0) || ({1'b0, r_x} == LP_H_ACT - 11'd1) ||
        (r_y == '0) || ({1'b0, r_y} == 11'(V_ACT - 1))) begin
      w_r = '1;
      w_g = '1;
      w_b = '1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      R  <= '0;
      G  <= '0;
      B  <= '0;
      HS <= 1'b0;
      VS <= 1'b0;
      DE <= 1'b0;
    end else begin
      HS <= r_hs1;
      VS <= r_vs1;
      DE <= r_draw1;
      if (r_draw1) begin
        R <= w_r;
        G <= w_g;
        B <= w_b;
      end else begin
        R <= '0;
        G <= '0;
        B <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_gen
//   Directed bench for vga_pattern_gen: a vector table of single pixels with
//   hand-computed colours, plus short sequences for reset, mode latching and
//   the bouncing box. Compile with +define+PATTERN_BORDER_EN for the border build.
// -----------------------------------------------------------------------------
module tb_vga_pattern_gen;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [9:0] H_CNT;
  logic [9:0] V_CNT;
  logic       DRAW_I;
  logic       HS_I;
  logic       VS_I;
  logic [1:0] MODE;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;
  logic       HS;
  logic       VS;
  logic       DE;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  vga_pattern_gen #(
    .H_START (144),
    .V_START (35),
    .H_ACT   (640),
    .V_ACT   (480),
    .BOX_SIZE(32),
    .SPEED   (2)
  ) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .H_CNT (H_CNT),
    .V_CNT (V_CNT),
    .DRAW_I(DRAW_I),
    .HS_I  (HS_I),
    .VS_I  (VS_I),
    .MODE  (MODE),
    .R     (R),
    .G     (G),
    .B     (B),
    .HS    (HS),
    .VS    (VS),
    .DE    (DE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] mode;
    logic [9:0] h;
    logic [9:0] v;
    logic       draw;
    logic       hs;
    logic [7:0] er;
    logic [7:0] eg;
    logic [7:0] eb;
    logic       ede;
    logic       ehs;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [7:0] er, eg, eb,
                     input logic ede, ehs, evs);
    n_checks++;
    if ({R, G, B, DE, HS, VS} !== {er, eg, eb, ede, ehs, evs}) begin
      n_errors++;
      $display("FAIL %s: got R=%0d G=%0d B=%0d DE=%b HS=%b VS=%b want R=%0d G=%0d B=%0d DE=%b HS=%b VS=%b",
               name, R, G, B, DE, HS, VS, er, eg, eb, ede, ehs, evs);
    end
  endtask

  // Hold one pixel on the inputs and wait out the 2-cycle latency.
  task automatic apply_px(input logic [9:0] h, v, input logic d, hs);
    @(negedge CLK);
    H_CNT  = h;
    V_CNT  = v;
    DRAW_I = d;
    HS_I   = hs;
    VS_I   = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
  endtask

  // One-cycle VS_I pulse: one frame start, MODE latched, box steps once.
  task automatic vs_pulse(input logic [1:0] m);
    @(negedge CLK);
    MODE   = m;
    DRAW_I = 1'b0;
    HS_I   = 1'b0;
    VS_I   = 1'b1;
    @(negedge CLK);
    VS_I   = 1'b0;
  endtask

  task automatic px_chk(input string name, input logic [9:0] h, v,
                        input logic [7:0] er, eg, eb);
    apply_px(h, v, 1'b1, 1'b0);
    chk(name, er, eg, eb, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] cur_mode;

    //                mode  h     v    d  hs   R    G    B   DE HS
    tbl[0]  = '{2'd0, 229, 100, 1, 0, 255, 255,   0, 1, 0}; // x=85 yellow
    tbl[1]  = '{2'd0, 229, 100, 0, 0,   0,   0,   0, 0, 0}; // blanked
    tbl[2]  = '{2'd0, 144, 100, 1, 0, 255, 255, 255, 1, 0}; // x=0 white
    tbl[3]  = '{2'd0, 223, 100, 1, 0, 255, 255, 255, 1, 0}; // x=79 white
    tbl[4]  = '{2'd0, 224, 100, 1, 0, 255, 255,   0, 1, 0}; // x=80 yellow
    tbl[5]  = '{2'd0, 304, 100, 1, 0,   0, 255, 255, 1, 0}; // cyan
    tbl[6]  = '{2'd0, 384, 100, 1, 0,   0, 255,   0, 1, 0}; // green
    tbl[7]  = '{2'd0, 464, 100, 1, 0, 255,   0, 255, 1, 0}; // magenta
    tbl[8]  = '{2'd0, 544, 100, 1, 0, 255,   0,   0, 1, 0}; // red
    tbl[9]  = '{2'd0, 624, 100, 1, 0,   0,   0, 255, 1, 0}; // blue
    tbl[10] = '{2'd0, 704, 100, 1, 0,   0,   0,   0, 1, 0}; // black bar
    tbl[11] = '{2'd0, 784, 100, 1, 0,   0,   0,   0, 1, 0}; // x=640 black
    tbl[12] = '{2'd0, 229, 100, 1, 1, 255, 255,   0, 1, 1}; // HS passes
    tbl[13] = '{2'd1, 176,  35, 1, 0, 255, 255, 255, 1, 0}; // (32,0) white
    tbl[14] = '{2'd1, 176,  67, 1, 0,   0,   0,   0, 1, 0}; // (32,32) black
    tbl[15] = '{2'd1, 175,  40, 1, 0,   0,   0,   0, 1, 0}; // (31,5) black
    tbl[16] = '{2'd2, 444, 235, 1, 0,  44, 200, 250, 1, 0}; // (300,200)
`ifdef PATTERN_BORDER_EN
    tbl[17] = '{2'd2, 144, 135, 1, 0, 255, 255, 255, 1, 0}; // (0,100) border
`else
    tbl[17] = '{2'd2, 144, 135, 1, 0,   0, 100,  50, 1, 0}; // (0,100)
`endif
    tbl[18] = '{2'd2,   0, 135, 1, 0, 112, 100, 234, 1, 0}; // x wraps to 880
    tbl[19] = '{2'd2, 444, 235, 0, 1,   0,   0,   0, 0, 1}; // blanked, HS

    // Reset with busy inputs: outputs must be zero.
    CLR = 1'b1; H_CNT = 10'd229; V_CNT = 10'd100;
    DRAW_I = 1'b1; HS_I = 1'b1; VS_I = 1'b0; MODE = 2'd3;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("reset", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    CLR = 1'b0; DRAW_I = 1'b0; HS_I = 1'b0;

    // Frame start with MODE=0; VS emerges 2 cycles after VS_I rises.
    @(negedge CLK);
    MODE = 2'd0; VS_I = 1'b1;
    @(negedge CLK);
    VS_I = 1'b0;
    @(posedge CLK);
    #1;
    chk("vs_latency", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    cur_mode = 2'd0;

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].mode != cur_mode) begin
        vs_pulse(tbl[i].mode);
        cur_mode = tbl[i].mode;
      end
      apply_px(tbl[i].h, tbl[i].v, tbl[i].draw, tbl[i].hs);
      chk($sformatf("vec%0d", i), tbl[i].er, tbl[i].eg, tbl[i].eb,
          tbl[i].ede, tbl[i].ehs, 1'b0);
    end

    // Mode change mid-frame only takes effect at the next frame start.
    vs_pulse(2'd0);
    @(negedge CLK);
    MODE = 2'd2;
    px_chk("latch_hold", 10'd229, 10'd100, 8'd255, 8'd255, 8'd0);
    vs_pulse(2'd2);
    px_chk("latch_next", 10'd229, 10'd100, 8'd85, 8'd65, 8'd75);

    // Five more frames (10 total): box at (20,20).
    for (int i = 0; i < 5; i++) vs_pulse(2'd3);
    px_chk("box10_in",  10'd164, 10'd55, 8'd255, 8'd127, 8'd64);
    px_chk("box10_out", 10'd163, 10'd55, 8'd0,   8'd0,   8'd64);

    // CLR mid-line with a lit pixel in flight.
    @(negedge CLK);
    H_CNT = 10'd164; V_CNT = 10'd55; DRAW_I = 1'b1; HS_I = 1'b1;
    @(negedge CLK);
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    chk("clr_midline", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    CLR = 1'b0; HS_I = 1'b0;
    // Mode register cleared to bars without any frame start.
    px_chk("clr_mode", 10'd229, 10'd100, 8'd255, 8'd255, 8'd0);

    // Box restarts from (0,0) moving +/+.
    for (int i = 0; i < 3; i++) vs_pulse(2'd3);
    px_chk("box3_in",    10'd150, 10'd41, 8'd255, 8'd127, 8'd64); // (6,6)
    px_chk("box3_left",  10'd149, 10'd41, 8'd0,   8'd0,   8'd64); // (5,6)
    px_chk("box3_right", 10'd181, 10'd41, 8'd255, 8'd127, 8'd64); // (37,6)
    px_chk("box3_past",  10'd182, 10'd41, 8'd0,   8'd0,   8'd64); // (38,6)

    for (int i = 0; i < 301; i++) vs_pulse(2'd3);
    px_chk("box304_in",   10'd752, 10'd323, 8'd255, 8'd127, 8'd64); // (608,288)
    px_chk("box304_left", 10'd751, 10'd323, 8'd0,   8'd0,   8'd64); // (607,288)
    px_chk("box304_up",   10'd752, 10'd322, 8'd0,   8'd0,   8'd64); // (608,287)

    vs_pulse(2'd3);
    px_chk("box305_in",     10'd750, 10'd321, 8'd255, 8'd127, 8'd64); // (606,286)
    px_chk("box305_rlast",  10'd781, 10'd321, 8'd255, 8'd127, 8'd64); // (637,286)
    px_chk("box305_rpast",  10'd782, 10'd321, 8'd0,   8'd0,   8'd64); // (638,286)
    px_chk("box305_blast",  10'd750, 10'd352, 8'd255, 8'd127, 8'd64); // (606,317)
    px_chk("box305_bpast",  10'd750, 10'd353, 8'd0,   8'd0,   8'd64); // (606,318)

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
